bcd_addsub_serial: RTL
======================

Name: bcd_addsub_serial

Overview:
- Digit-serial, parametrised BCD adder/subtractor.
- Generalises the fixed two-digit combinational BCD adder to DIGITS digits.
- Processes one 4-bit BCD digit per clock, least significant digit first, with valid/ready handshakes on input and output.
- Sits between operand registers and a display or ALU result path.

Parameters:
- DIGITS, 4, number of BCD digits per operand; legal range 1..16.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sub are valid this cycle.
- in_ready  output  1  block idle; can accept an operation.
- a  input  4*DIGITS  operand A; digit i at bits [4i+3:4i].
- b  input  4*DIGITS  operand B; same layout.
- sub  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- s  output  4*DIGITS  BCD result.
- cout  output  1  add: decimal carry out; sub: borrow (1 = A<B).
- neg  output  1  result is a negated magnitude (feature only; constant 0 otherwise).
- err  output  1  at least one operand digit was >9.

Behaviour:
- Reset (async, rst_n=0): state IDLE; s=0, cout=0, neg=0, err=0, out_valid=0; in_ready=1.
  - Reset mid-operation aborts the operation; no partial result is delivered.
- FSM states: IDLE, ADD, FIX (feature only), DONE.
- in_ready=1 only in IDLE. in_valid in any other state is ignored.
- Accept (IDLE, in_valid=1):
  - Latch a, b, sub.
  - Clear s, err, neg.
  - Digit index = 0; carry = sub.
  - Go to ADD.
- ADD, one digit per cycle:
  - bd = sub ? (9 − b_i) mod 16 : b_i.
  - t = a_i + bd + carry, 5-bit.
  - If t>9: digit = (t+6)[3:0], carry = 1; else digit = t[3:0], carry = 0.
  - Write digit into s slot i.
  - err |= (a_i>9) | (b_i>9).
  - After digit DIGITS−1: cout = sub ? ~carry : carry, then go to DONE (or FIX, see feature).
- Latency: out_valid rises exactly DIGITS cycles after the accepting edge.
- DONE:
  - out_valid=1.
  - s, cout, neg, err held stable until out_ready=1.
  - On out_ready=1, next state IDLE; out_valid drops on that edge.
  - s, cout, neg, err keep their values until the next accept.
- Wrap-around:
  - Add overflow gives s = sum mod 10^DIGITS, cout=1.
  - Without the feature, a negative subtraction gives the ten's complement (10^DIGITS + A − B) with cout=1.
- err=1 makes s undefined; cout is still computed per the rule above. err is sticky only for the current operation.
- No back-to-back overlap: minimum issue interval is DIGITS+2 cycles.

Optional Feature:
- Macro: BCD_NEG_MAGNITUDE_EN.
- Defined:
  - When sub=1 and borrow=1 after ADD, enter FIX for DIGITS cycles.
  - FIX computes s_i = 9 − s_i + carry (carry starts at 1, same +6 correction), yielding |A−B|.
  - neg=1 on entry to FIX; cout remains 1.
  - Latency in this case is 2*DIGITS cycles. All other cases are unchanged.
- Not defined:
  - FIX state absent; ADD always goes to DONE.
  - neg tied 0; ten's complement result as above.

Decomposition:
- Package bcd_pkg:
  - digit_t (logic [3:0]).
  - State enum state_t.
  - Constant BCD_MAX = 9.
  - Function nines_comp(digit_t).
- One combinational sub-module, bcd_digit_adder (a, b, ci → s, co, bad):
  - Single-digit add with +6 correction.
  - Shared by ADD and FIX through an operand mux.

Test Plan:
- DIGITS=4, a=0x1234, b=0x5678, sub=0 → after 4 cycles out_valid=1, s=0x6912, cout=0, err=0.
- a=0x9999, b=0x0001, sub=0 → s=0x0000, cout=1.
- a=0x0500, b=0x0123, sub=1 → s=0x0377, cout=0, neg=0.
- a=0x0003, b=0x0005, sub=1:
  - Without macro: s=0x9998, cout=1, neg=0, out_valid after 4 cycles.
  - With BCD_NEG_MAGNITUDE_EN: s=0x0002, cout=1, neg=1, out_valid after 8 cycles.
- a=0x00A1, b=0x0001, sub=0 → err=1; then a=0x0001, b=0x0001 → err=0, s=0x0002.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE → s/cout stable, in_ready=0, in_valid pulses ignored.
  - Assert rst_n=0 mid-ADD → immediately out_valid=0, s=0, in_ready=1.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
// FIX exists only when BCD_NEG_MAGNITUDE_EN is defined.
package bcd_pkg;

  typedef logic [3:0] digit_t;

`ifdef BCD_NEG_MAGNITUDE_EN
  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
`endif

  localparam digit_t BCD_MAX = 4'd9;

  // Nine's complement wraps mod 16, so out-of-range digits stay out of range.
  function automatic digit_t nines_comp(digit_t d);
    return digit_t'(BCD_MAX - d);
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single BCD digit adder with +6 decimal correction.
// Flags any operand digit above 9.
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);

  logic [4:0] t;
  logic [4:0] t_fix;

  always_comb begin
    t     = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    t_fix = t + 5'd6;
    if (t > 5'd9) begin
      s  = t_fix[3:0];
      co = 1'b1;
    end else begin
      s  = t[3:0];
      co = 1'b0;
    end
    bad = (a > BCD_MAX) | (b > BCD_MAX);
  end

endmodule

// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor, one digit per clock, LSD first.
// Define BCD_NEG_MAGNITUDE_EN to return |A-B| with neg=1 for negative differences.
module bcd_addsub_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   s,
  output logic                  cout,
  output logic                  neg,
  output logic                  err
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t               state_reg;
  logic [4*DIGITS-1:0]  a_reg;
  logic [4*DIGITS-1:0]  b_reg;
  logic                 sub_reg;
  logic [IW-1:0]        idx_reg;
  logic                 carry_reg;
  logic                 cout_reg;
  logic                 err_reg;
  logic                 out_valid_reg;
  logic                 in_ready_reg;
  digit_t               s_dig_reg [DIGITS];

  digit_t a_dig [DIGITS];
  digit_t b_dig [DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_dig
      assign a_dig[gi]        = a_reg[4*gi +: 4];
      assign b_dig[gi]        = b_reg[4*gi +: 4];
      assign s[4*gi +: 4]     = s_dig_reg[gi];
    end
  endgenerate

  // One adder serves both passes; FIX re-adds the nine's complement of the result.
  digit_t op_x;
  digit_t op_y;
  digit_t sum;
  logic   co;
  logic   bad;

  always_comb begin
    op_x = a_dig[idx_reg];
    op_y = sub_reg ? nines_comp(b_dig[idx_reg]) : b_dig[idx_reg];
`ifdef BCD_NEG_MAGNITUDE_EN
    if (state_reg == FIX) begin
      op_x = nines_comp(s_dig_reg[idx_reg]);
      op_y = 4'd0;
    end
`endif
  end

  bcd_digit_adder u_digit (
    .a   (op_x),
    .b   (op_y),
    .ci  (carry_reg),
    .s   (sum),
    .co  (co),
    .bad (bad)
  );

`ifdef BCD_NEG_MAGNITUDE_EN
  logic neg_reg;
  assign neg = neg_reg;
`else
  assign neg = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign cout      = cout_reg;
  assign err       = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sub_reg       <= 1'b0;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      for (int i = 0; i < DIGITS; i++) s_dig_reg[i] <= '0;
`ifdef BCD_NEG_MAGNITUDE_EN
      neg_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            sub_reg      <= sub;
            idx_reg      <= '0;
            carry_reg    <= sub;
            err_reg      <= 1'b0;
            in_ready_reg <= 1'b0;
            for (int i = 0; i < DIGITS; i++) s_dig_reg[i] <= '0;
`ifdef BCD_NEG_MAGNITUDE_EN
            neg_reg      <= 1'b0;
`endif
            state_reg    <= ADD;
          end
        end

        ADD: begin
          s_dig_reg[idx_reg] <= sum;
          carry_reg          <= co;
          err_reg            <= err_reg | bad;
          if (idx_reg == LAST) begin
            cout_reg <= sub_reg ? ~co : co;
            idx_reg  <= '0;
`ifdef BCD_NEG_MAGNITUDE_EN
            if (sub_reg && !co) begin
              neg_reg   <= 1'b1;
              carry_reg <= 1'b1;
              state_reg <= FIX;
            end else begin
              out_valid_reg <= 1'b1;
              state_reg     <= DONE;
            end
`else
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
`endif
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end

`ifdef BCD_NEG_MAGNITUDE_EN
        FIX: begin
          s_dig_reg[idx_reg] <= sum;
          carry_reg          <= co;
          if (idx_reg == LAST) begin
            idx_reg       <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
`endif

        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

endmodule
